// File: rtl/arb_seq.sv
// Multi-channel arbitrary waveform sequencer: per-channel sample memories played back
// through a shared address sequencer with single, counted or continuous passes.
module arb_seq #(
    parameter int unsigned DAC_DATA_WIDTH = 14,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned N_CH           = 2
) (
    input  logic                             dac_clk,
    input  logic                             rst_n,
    input  logic                             we,
    input  logic [N_CH-1:0]                  wsel,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DAC_DATA_WIDTH-1:0]        wdata,
    input  logic [ADDR_WIDTH-1:0]            start_addr,
    input  logic [ADDR_WIDTH-1:0]            stop_addr,
    input  logic [1:0]                       mode,
    input  logic [15:0]                      loop_cnt,
    input  logic                             trig,
    input  logic                             abort,
    output logic [N_CH*DAC_DATA_WIDTH-1:0]   dac_dat,
    output logic                             dac_valid,
    output logic                             busy,
    output logic                             done,
    output logic [15:0]                      pass_idx
);

    localparam int unsigned DW = N_CH * DAC_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0]   start_q, start_d;
    logic [ADDR_WIDTH-1:0]   stop_q, stop_d;
    logic [1:0]              mode_q, mode_d;
    logic [15:0]             lc_q, lc_d;
    logic [15:0]             pass_q, pass_d;
    logic                    rd_v_q, rd_v_d;
    logic [15:0]             rd_pass_q, rd_pass_d;
    logic [DW-1:0]           rd_dat_q;
    logic [DW-1:0]           dat_q, dat_d;
    logic                    val_q, val_d;
    logic                    done_q, done_d;
    logic [15:0]             pidx_q, pidx_d;
    logic [15:0]             lc_eff;
    logic                    last_pass;

    logic [DAC_DATA_WIDTH-1:0] mem [N_CH][2**ADDR_WIDTH];

    // Read-first: the read register samples the array before this edge's write lands.
    always_ff @(posedge dac_clk) begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (we && wsel[c]) begin
                mem[c][waddr] <= wdata;
            end
            rd_dat_q[c*DAC_DATA_WIDTH +: DAC_DATA_WIDTH] <= mem[c][raddr_q];
        end
    end

    assign lc_eff    = (lc_q == 16'd0) ? 16'd1 : lc_q;
    assign last_pass = (mode_q == 2'b10) ? 1'b0 :
                       (mode_q == 2'b01) ? (({1'b0, pass_q} + 17'd1) >= {1'b0, lc_eff}) :
                       1'b1;

    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        start_d   = start_q;
        stop_d    = stop_q;
        mode_d    = mode_q;
        lc_d      = lc_q;
        pass_d    = pass_q;
        rd_v_d    = 1'b0;
        rd_pass_d = pass_q;
        val_d     = rd_v_q;
        dat_d     = rd_v_q ? rd_dat_q : '0;
        pidx_d    = rd_v_q ? rd_pass_q : pidx_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig && !abort) begin
                    state_d = RUN;
                    start_d = start_addr;
                    stop_d  = stop_addr;
                    mode_d  = mode;
                    lc_d    = loop_cnt;
                    raddr_d = start_addr;
                    pass_d  = 16'd0;
                    pidx_d  = 16'd0;
                end
            end
            RUN: begin
                rd_v_d = 1'b1;
                if (raddr_q == stop_q) begin
                    if (last_pass) begin
                        state_d = FLUSH;
                        raddr_d = raddr_q + 1'b1;
                    end else begin
                        raddr_d = start_q;
                        pass_d  = pass_q + 16'd1;
                    end
                end else begin
                    raddr_d = raddr_q + 1'b1;
                end
            end
            FLUSH: begin
                // Last sample is on the output now; done lands as it drops.
                if (!rd_v_q && val_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            rd_v_d  = 1'b0;
            val_d   = 1'b0;
            dat_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge dac_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            raddr_q   <= '0;
            start_q   <= '0;
            stop_q    <= '0;
            mode_q    <= '0;
            lc_q      <= '0;
            pass_q    <= '0;
            rd_v_q    <= 1'b0;
            rd_pass_q <= '0;
            dat_q     <= '0;
            val_q     <= 1'b0;
            done_q    <= 1'b0;
            pidx_q    <= '0;
        end else begin
            state_q   <= state_d;
            raddr_q   <= raddr_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            mode_q    <= mode_d;
            lc_q      <= lc_d;
            pass_q    <= pass_d;
            rd_v_q    <= rd_v_d;
            rd_pass_q <= rd_pass_d;
            dat_q     <= dat_d;
            val_q     <= val_d;
            done_q    <= done_d;
            pidx_q    <= pidx_d;
        end
    end

    assign dac_dat   = dat_q;
    assign dac_valid = val_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign pass_idx  = pidx_q;

endmodule

// File: tb/tb_arb_seq.sv
// Scoreboard bench for arb_seq (ADDR_WIDTH=4, two channels): stimulus queues expected
// samples, a negedge monitor pops and compares every valid output.
module tb_arb_seq;

    localparam int unsigned W  = 14;
    localparam int unsigned AW = 4;
    localparam int unsigned NC = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            we;
    logic [NC-1:0]   wsel;
    logic [AW-1:0]   waddr;
    logic [W-1:0]    wdata;
    logic [AW-1:0]   start_addr, stop_addr;
    logic [1:0]      mode;
    logic [15:0]     loop_cnt;
    logic            trig, abort;
    logic [NC*W-1:0] dac_dat;
    logic            dac_valid, busy, done;
    logic [15:0]     pass_idx;

    typedef struct {
        logic [W-1:0] c0;
        logic [W-1:0] c1;
        logic [15:0]  p;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nerr = 0;

    arb_seq #(.DAC_DATA_WIDTH(W), .ADDR_WIDTH(AW), .N_CH(NC)) dut (
        .dac_clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .waddr(waddr), .wdata(wdata),
        .start_addr(start_addr), .stop_addr(stop_addr), .mode(mode), .loop_cnt(loop_cnt),
        .trig(trig), .abort(abort), .dac_dat(dac_dat), .dac_valid(dac_valid),
        .busy(busy), .done(done), .pass_idx(pass_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per valid output cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dac_valid === 1'b1) begin
                ncmp++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_sample: got dat=%0h pass=%0d with no expectation", dac_dat, pass_idx);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (dac_dat !== {e.c1, e.c0} || pass_idx !== e.p) begin
                        nerr++;
                        $display("FAIL sample: got dat=%0h pass=%0d expected dat=%0h pass=%0d",
                                 dac_dat, pass_idx, {e.c1, e.c0}, e.p);
                    end
                end
            end else begin
                ncmp++;
                if (dac_dat !== '0) begin
                    nerr++;
                    $display("FAIL dat_idle_zero: got %0h expected 0", dac_dat);
                end
            end
        end
    end

    task automatic push(input int c0, input int c1, input int p);
        exp_t e;
        e.c0 = W'(c0);
        e.c1 = W'(c1);
        e.p  = 16'(p);
        q.push_back(e);
    endtask

    // All tasks start and end at #1 after a rising edge.
    task automatic wr(input logic [NC-1:0] sel, input int a, input int d);
        we = 1'b1; wsel = sel; waddr = AW'(a); wdata = W'(d);
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic cfg(input int s, input int e, input logic [1:0] m, input int lc);
        start_addr = AW'(s); stop_addr = AW'(e); mode = m; loop_cnt = 16'(lc);
    endtask

    task automatic play(input string tag, input int exp_n, input int exp_done,
                        input int we_edge, input int wa, input int wd,
                        input int abort_after, input bit hold_trig);
        int nvalid = 0, ndone = 0, first = -1, done_t = -1, abort_t = -1;
        logic busy_done = 1'b1;
        trig = 1'b1;
        @(posedge clk); #1;
        trig = hold_trig;
        cfg($urandom, $urandom, 2'($urandom), $urandom);
        for (int t = 1; t <= exp_n + 6; t++) begin
            we = (t == we_edge); wsel = '1; waddr = AW'(wa); wdata = W'(wd);
            @(posedge clk); #1;
            we = 1'b0;
            if (t == abort_t + 1 && abort_t >= 0) begin
                abort = 1'b0;
                chk({tag, "_abort_valid"}, 64'(dac_valid), 64'd0);
                chk({tag, "_abort_dat"},   64'(dac_dat),   64'd0);
                chk({tag, "_abort_busy"},  64'(busy),      64'd0);
            end
            if (dac_valid) begin
                nvalid++;
                if (first < 0) first = t;
            end
            if (done) begin
                ndone++;
                done_t = t;
                busy_done = busy;
            end
            if (abort_after > 0 && dac_valid && nvalid == abort_after && abort_t < 0) begin
                abort = 1'b1;
                trig = 1'b0;
                abort_t = t;
            end
        end
        trig = 1'b0;
        if (exp_n > 0) chk({tag, "_first_valid"}, 64'(first), 64'd2);
        chk({tag, "_n_valid"}, 64'(nvalid), 64'(exp_n));
        chk({tag, "_n_done"},  64'(ndone),  64'(exp_done));
        if (exp_done > 0) begin
            chk({tag, "_done_cycle"},   64'(done_t),    64'(exp_n + 2));
            chk({tag, "_busy_at_done"}, 64'(busy_done), 64'd0);
        end
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; wsel = '0; waddr = '0; wdata = '0;
        trig = 1'b0; abort = 1'b0;
        cfg(0, 0, 2'b00, 0);
        #3;
        chk("rst_valid", 64'(dac_valid), 64'd0);
        chk("rst_dat",   64'(dac_dat),   64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_pass",  64'(pass_idx),  64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            wr(2'b01, i, 10 + i);
            wr(2'b10, i, 100 + i);
        end
        wr(2'b01, 14, 20); wr(2'b10, 14, 120);
        wr(2'b01, 15, 21); wr(2'b10, 15, 121);

        // single pass 0..3
        for (int i = 0; i < 4; i++) push(10 + i, 100 + i, 0);
        cfg(0, 3, 2'b00, 5);
        play("single", 4, 1, -1, 0, 0, 0, 1'b0);

        // three passes
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 4; i++) push(10 + i, 100 + i, p);
        cfg(0, 3, 2'b01, 3);
        play("loop3", 12, 1, -1, 0, 0, 0, 1'b0);

        // loop_cnt 0 behaves as one pass
        for (int i = 0; i < 4; i++) push(10 + i, 100 + i, 0);
        cfg(0, 3, 2'b01, 0);
        play("loop0", 4, 1, -1, 0, 0, 0, 1'b0);

        // reserved mode behaves as single
        for (int i = 0; i < 4; i++) push(10 + i, 100 + i, 0);
        cfg(0, 3, 2'b11, 9);
        play("mode11", 4, 1, -1, 0, 0, 0, 1'b0);

        // window wrapping through address 0
        push(20, 120, 0); push(21, 121, 0); push(10, 100, 0); push(11, 101, 0);
        cfg(14, 1, 2'b00, 0);
        play("wrap", 4, 1, -1, 0, 0, 0, 1'b0);

        // trig with abort in IDLE does not start
        cfg(0, 3, 2'b00, 0);
        trig = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0; abort = 1'b0;
        chk("trig_abort_busy", 64'(busy), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("trig_abort_valid", 64'(dac_valid), 64'd0);

        // continuous, trig held, abort after 7 samples
        push(10, 100, 0); push(11, 101, 0); push(12, 102, 0);
        push(10, 100, 1); push(11, 101, 1); push(12, 102, 1);
        push(10, 100, 2);
        cfg(0, 2, 2'b10, 0);
        play("cont_abort", 7, 0, -1, 0, 0, 7, 1'b1);

        // reset mid-playback
        push(10, 100, 0);
        cfg(0, 3, 2'b00, 0);
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(dac_valid), 64'd0);
        chk("midrst_dat",   64'(dac_dat),   64'd0);
        chk("midrst_busy",  64'(busy),      64'd0);
        chk("midrst_done",  64'(done),      64'd0);
        chk("midrst_pass",  64'(pass_idx),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) push(10 + i, 100 + i, 0);
        cfg(0, 3, 2'b00, 0);
        play("restart", 4, 1, -1, 0, 0, 0, 1'b0);

        // channel masks and read-first during playback
        wr(2'b11, 0, 50);
        wr(2'b01, 0, 60);
        push(60, 50, 0); push(11, 101, 0);
        cfg(0, 1, 2'b00, 0);
        play("rdfirst", 2, 1, 2, 1, 77, 0, 1'b0);
        push(77, 77, 0);
        cfg(1, 1, 2'b00, 0);
        play("len1", 1, 1, -1, 0, 0, 0, 1'b0);

        @(posedge clk); #1;
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/arb_seq.md
ARB_SEQ -- requirements
Module: arb_seq

Interface
REQ-001 SHALL have parameter DAC_DATA_WIDTH, default 14, sample width per channel.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, waveform memory address width (depth 2**ADDR_WIDTH per channel).
REQ-003 SHALL have parameter N_CH, default 2, number of channels sharing one sequencer.
REQ-004 dac_clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 we  in  1  memory write strobe.
REQ-007 wsel  in  N_CH  one-hot/multi-hot channel write mask.
REQ-008 waddr  in  ADDR_WIDTH  write address.
REQ-009 wdata  in  DAC_DATA_WIDTH  write sample.
REQ-010 start_addr, stop_addr  in  ADDR_WIDTH each  playback window.
REQ-011 mode  in  2  00 single pass, 01 loop_cnt passes, 10 continuous, 11 reserved (treated as 00).
REQ-012 loop_cnt  in  16  pass count for mode 01.
REQ-013 trig  in  1  start request; abort  in  1  stop request.
REQ-014 dac_dat  out  N_CH*DAC_DATA_WIDTH  channel c in bits [c*DAC_DATA_WIDTH +: DAC_DATA_WIDTH].
REQ-015 dac_valid  out  1  dac_dat holds a playback sample.
REQ-016 busy  out  1; done  out  1 (one-cycle pulse); pass_idx  out  16  current pass number, 0-based.

Function
REQ-017 Writes: on edge with we=1, every channel c with wsel[c]=1 SHALL store wdata at waddr; writes allowed in any state.
REQ-018 Same-cycle read and write of one address SHALL return the old data (read-first).
REQ-019 FSM states IDLE, RUN, FLUSH.
REQ-020 IDLE: trig=1 and abort=0 SHALL latch start_addr, stop_addr, mode, loop_cnt, set raddr=start_addr, pass_idx=0, busy=1, go RUN; config inputs ignored until return to IDLE.
REQ-021 RUN: each cycle SHALL read all channels at raddr into a memory register and advance raddr by 1 modulo 2**ADDR_WIDTH.
REQ-022 Pass length SHALL be L=((stop-start) mod 2**ADDR_WIDTH)+1; start>stop wraps through address 0; start=stop gives L=1.
REQ-023 At raddr=stop: if more passes remain, next raddr=start_addr and pass_idx increments, no gap cycle; else go FLUSH.
REQ-024 Passes: mode 00 -> 1; mode 01 -> loop_cnt, loop_cnt=0 treated as 1; mode 10 -> unbounded, pass_idx wraps 0xFFFF->0.
REQ-025 Read latency SHALL be 2 cycles: trig sampled on edge k -> first sample (start_addr) on dac_dat with dac_valid=1 after edge k+2; consecutive samples every cycle thereafter.
REQ-026 FLUSH: SHALL last until final sample has been presented, then go IDLE with busy=0, dac_valid=0, and done=1 for exactly the cycle after the last dac_valid cycle.
REQ-027 dac_dat SHALL be 0 whenever dac_valid=0.
REQ-028 trig while busy=1 SHALL be ignored.
REQ-029 abort=1 in RUN or FLUSH SHALL, at next edge, force IDLE, busy=0, dac_valid=0, dac_dat=0, discard pipeline; done SHALL NOT pulse.
REQ-030 trig and abort together in IDLE: abort wins, no start.

Reset
REQ-031 rst_n=0 SHALL immediately set state IDLE, raddr=0, pass_idx=0, busy=0, done=0, dac_valid=0, dac_dat=0; memory contents are not cleared.
REQ-032 Reset mid-playback SHALL abandon the sequence; first cycle after release is IDLE.

Verification
REQ-033 Write addr 0..3 = 10,11,12,13 ch0; start=0, stop=3, mode 00, trig at edge k -> dac_valid after k+2..k+5 with 10,11,12,13; done at k+6; busy low at k+6.
REQ-034 Same data, mode 01, loop_cnt=3 -> 12 contiguous valid samples 10..13 x3, pass_idx 0,1,2, single done.
REQ-035 ADDR_WIDTH=4, start=14, stop=1, mode 00 -> samples from addresses 14,15,0,1, done after 4 valid cycles.
REQ-036 Mode 10, abort after 7 valid samples -> next cycle dac_valid=0, dac_dat=0, busy=0, no done; trig held during RUN ignored.
REQ-037 wsel=2'b11 write then wsel=2'b01 overwrite addr 0 -> ch0 plays new value, ch1 old; write during RUN to playing address returns old value that cycle.
REQ-038 rst_n low during RUN -> all outputs 0 asynchronously; after release, trig restarts cleanly from start_addr with 2-cycle latency.
